// File: rtl/mmio_rgb_pwm_if.sv
// Data-memory bus bundle between the core (master) and the RGB PWM responder (slave).
interface mmio_rgb_pwm_if;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic        dmem_wren;
  logic        dmem_rden;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output dmem_address, dmem_data_in, dmem_wren, dmem_rden,
    input  rdata, rvalid
  );

  modport slave (
    input  dmem_address, dmem_data_in, dmem_wren, dmem_rden,
    output rdata, rvalid
  );
endinterface

// File: rtl/mmio_rgb_pwm.sv
// Memory-mapped LED/RGB PWM responder with double-buffered duties and a prescaled 8-bit counter.
// Define MMIO_RGB_PWM_READBACK_EN to enable register readback and the sticky STATUS logic.
module mmio_rgb_pwm #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic               clk,
  input  logic               reset,
  mmio_rgb_pwm_if.slave      bus,
  output logic               led,
  output logic               red,
  output logic               green,
  output logic               blue
);

  // Channel index: 0 = led, 1 = red, 2 = green, 3 = blue.
  logic             en_q, en_d;
  logic [15:0]      prescale_q, prescale_d;
  logic [15:0]      presc_cnt_q, presc_cnt_d;
  logic [7:0]       count_q, count_d;
  logic [3:0][7:0]  shadow_q, shadow_d;
  logic [3:0][7:0]  active_q, active_d;
  logic [3:0]       pins_q, pins_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             hit;
  logic [2:0]       off;
  logic             wr;
  logic             tick;
  logic             wrap;
  logic [3:0]       on;

`ifdef MMIO_RGB_PWM_READBACK_EN
  logic             wrap_seen_q, wrap_seen_d;
  logic             unused_bits;
  assign unused_bits = ^{bus.dmem_address[1:0], bus.dmem_data_in[31:16]};
`else
  logic             unused_bits;
  assign unused_bits = ^{bus.dmem_address[1:0], bus.dmem_data_in[31:16], bus.dmem_data_in[1]};
`endif

  assign hit  = (bus.dmem_address[31:5] == BASE_ADDR[31:5]);
  assign off  = bus.dmem_address[4:2];
  assign wr   = bus.dmem_wren && hit;
  assign tick = en_q && (presc_cnt_q == prescale_q);
  assign wrap = tick && (count_q == 8'hFF);

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    en_d        = en_q;
    prescale_d  = prescale_q;
    shadow_d    = shadow_q;
    presc_cnt_d = presc_cnt_q;
    count_d     = count_q;
    active_d    = active_q;
    pins_d      = pins_q;

    if (wr) begin
      unique case (off)
        3'd0:    en_d          = bus.dmem_data_in[0];
        3'd1:    prescale_d    = bus.dmem_data_in[15:0];
        3'd2:    shadow_d[0]   = bus.dmem_data_in[7:0];
        3'd3:    shadow_d[1]   = bus.dmem_data_in[7:0];
        3'd4:    shadow_d[2]   = bus.dmem_data_in[7:0];
        3'd5:    shadow_d[3]   = bus.dmem_data_in[7:0];
        default: ;
      endcase
    end

    // Reprogramming the prescaler while running restarts its period; count is kept.
    if (!en_q || (wr && off == 3'd1) || tick) presc_cnt_d = 16'd0;
    else                                      presc_cnt_d = presc_cnt_q + 16'd1;

    if (!en_q)     count_d = 8'd0;
    else if (tick) count_d = count_q + 8'd1;

    // Duties become active only at a period boundary, or continuously while disabled.
    if (!en_q || wrap) active_d = shadow_q;

    for (int i = 0; i < 4; i++) on[i] = en_q && (count_q < active_q[i]);
    pins_d = {~on[3:1], on[0]};
  end

  always_comb begin
    rvalid_d = bus.dmem_rden && hit;
    rdata_d  = 32'd0;
`ifdef MMIO_RGB_PWM_READBACK_EN
    wrap_seen_d = wrap_seen_q;
    if (wrap)                                              wrap_seen_d = 1'b1;
    else if (wr && off == 3'd0 && bus.dmem_data_in[1])     wrap_seen_d = 1'b0;

    if (rvalid_d) begin
      unique case (off)
        3'd0:    rdata_d = {31'd0, en_q};
        3'd1:    rdata_d = {16'd0, prescale_q};
        3'd2:    rdata_d = {24'd0, shadow_q[0]};
        3'd3:    rdata_d = {24'd0, shadow_q[1]};
        3'd4:    rdata_d = {24'd0, shadow_q[2]};
        3'd5:    rdata_d = {24'd0, shadow_q[3]};
        3'd6:    rdata_d = {16'd0, count_q, 7'd0, wrap_seen_q};
        default: rdata_d = 32'd0;
      endcase
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q        <= 1'b0;
      prescale_q  <= 16'd0;
      presc_cnt_q <= 16'd0;
      count_q     <= 8'd0;
      shadow_q    <= '0;
      active_q    <= '0;
      pins_q      <= 4'b1110;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
    end else begin
      en_q        <= en_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pins_q      <= pins_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

`ifdef MMIO_RGB_PWM_READBACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_seen_q <= 1'b0;
    else        wrap_seen_q <= wrap_seen_d;
  end
`endif

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign led        = pins_q[0];
  assign red        = pins_q[1];
  assign green      = pins_q[2];
  assign blue       = pins_q[3];

endmodule

// File: tb/tb_mmio_rgb_pwm.sv
// Directed self-checking bench for mmio_rgb_pwm; readback expectations follow MMIO_RGB_PWM_READBACK_EN.
module tb_mmio_rgb_pwm;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef MMIO_RGB_PWM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic led, red, green, blue;
  int   n_tests = 0;
  int   n_fail = 0;

  mmio_rgb_pwm_if bus ();

  mmio_rgb_pwm #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led   (led),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit pin_on(input int ch);
    case (ch)
      0:       return led;
      1:       return !red;
      2:       return !green;
      default: return !blue;
    endcase
  endfunction

  task automatic bus_write(input logic [2:0] off, input logic [31:0] data);
    @(negedge clk);
    bus.dmem_address = BASE + {27'd0, off, 2'b00};
    bus.dmem_data_in = data;
    bus.dmem_wren    = 1'b1;
    @(negedge clk);
    bus.dmem_wren    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic valid);
    @(negedge clk);
    bus.dmem_address = addr;
    bus.dmem_rden    = 1'b1;
    @(negedge clk);
    bus.dmem_rden    = 1'b0;
    data  = bus.rdata;
    valid = bus.rvalid;
  endtask

  // Waits for an off->on transition, then measures on-time and full period; -1 on timeout.
  task automatic measure_on(input int ch, input int budget, output int on_len, output int period);
    int n = 0;
    bit prev, cur, found, done;
    prev = pin_on(ch);
    found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clk); n++;
      cur = pin_on(ch);
      found = !prev && cur;
      prev = cur;
    end
    on_len = -1; period = -1;
    if (!found) return;
    on_len = 1; period = 1; done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); n++;
      cur = pin_on(ch);
      if (cur && !prev) done = 1'b1;
      else begin
        period++;
        if (cur) on_len++;
      end
      prev = cur;
    end
    if (!done) begin on_len = -1; period = -1; end
  endtask

  logic [31:0] rd;
  logic        rv;
  int          on_len, period, on_cnt;

  initial begin
    bus.dmem_address = 32'd0;
    bus.dmem_data_in = 32'd0;
    bus.dmem_wren    = 1'b0;
    bus.dmem_rden    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_led", {31'd0, led}, 32'd0);
    check("rst_rgb", {29'd0, red, green, blue}, 32'd7);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b1;

    // Basic PWM, prescale 0
    bus_write(3'd1, 32'd0);
    bus_write(3'd3, 32'd64);
    bus_write(3'd0, 32'd1);
    measure_on(1, 700, on_len, period);
    check("red_on_len", on_len, 64);
    check("red_period", period, 256);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pin_on(2)) on_cnt++;
    end
    check("green_duty0_off", on_cnt, 0);

    // Duty 255 boundary
    bus_write(3'd2, 32'd255);
    measure_on(0, 700, on_len, period);
    check("led255_on_len", on_len, 255);
    check("led255_period", period, 256);

    // Double buffering: rewrite blue mid-period at count 50
    bus_write(3'd5, 32'd200);
    measure_on(3, 700, on_len, period);
    check("blue200_on_len", on_len, 200);
    on_cnt = 1;
    for (int i = 1; i < 300; i++) begin
      @(negedge clk);
      if (i == 49) begin
        bus.dmem_address = BASE + 32'd20;
        bus.dmem_data_in = 32'd10;
        bus.dmem_wren    = 1'b1;
      end else if (i == 50) begin
        bus.dmem_wren    = 1'b0;
      end
      if (!pin_on(3)) break;
      on_cnt++;
    end
    check("blue_cur_period", on_cnt, 200);
    measure_on(3, 700, on_len, period);
    check("blue10_on_len", on_len, 10);
    check("blue10_period", period, 256);

    // Readback and address decode
    bus_write(3'd4, 32'h0000_00A5);
    bus_read(BASE + 32'd16, rd, rv);
    check("rd_g_rvalid", {31'd0, rv}, 32'd1);
    check("rd_g_data", rd, RB ? 32'h0000_00A5 : 32'd0);
    bus_read(BASE + 32'd32, rd, rv);
    check("miss_rvalid", {31'd0, rv}, 32'd0);
    check("miss_rdata", rd, 32'd0);
    @(negedge clk);
    bus.dmem_address = BASE + 32'd12;
    bus.dmem_data_in = 32'd77;
    bus.dmem_wren    = 1'b1;
    bus.dmem_rden    = 1'b1;
    @(negedge clk);
    bus.dmem_wren    = 1'b0;
    bus.dmem_rden    = 1'b0;
    check("rw_same_rvalid", {31'd0, bus.rvalid}, 32'd1);
    check("rw_same_data", bus.rdata, RB ? 32'd64 : 32'd0);
    bus_read(BASE + 32'd28, rd, rv);
    check("rd_off7", rd, 32'd0);

    // Prescale 3 and sticky status
    bus_write(3'd0, 32'd2);
    bus_read(BASE + 32'd24, rd, rv);
    check("status_cleared", rd & 32'hFF, 32'd0);
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'd1);
    bus_write(3'd0, 32'd1);
    measure_on(0, 2200, on_len, period);
    check("ps3_on_len", on_len, 4);
    check("ps3_period", period, 1024);
    bus_read(BASE + 32'd24, rd, rv);
    check("status_wrap", rd & 32'hFF, RB ? 32'd1 : 32'd0);
    bus_write(3'd0, 32'd3);
    bus_read(BASE + 32'd24, rd, rv);
    check("status_clr", rd & 32'hFF, 32'd0);
    bus_read(BASE, rd, rv);
    check("ctrl_read", rd, RB ? 32'd1 : 32'd0);
    measure_on(0, 2200, on_len, period);
    check("ps3_still_en", period, 1024);

    // Disable
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'd0);
    on_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pin_on(0) || pin_on(1) || pin_on(2) || pin_on(3)) on_cnt++;
    end
    check("disabled_all_off", on_cnt, 0);
    bus_read(BASE + 32'd24, rd, rv);
    check("disabled_count", (rd >> 8) & 32'hFF, 32'd0);

    // Asynchronous reset mid-period
    bus_write(3'd2, 32'd128);
    bus_write(3'd0, 32'd1);
    measure_on(0, 700, on_len, period);
    check("led128_on_len", on_len, 128);
    repeat (20) @(negedge clk);
    check("led_on_before_rst", {31'd0, led}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_led", {31'd0, led}, 32'd0);
    check("arst_rgb", {29'd0, red, green, blue}, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus_read(BASE, rd, rv);
    check("post_rst_ctrl", rd, 32'd0);
    bus_read(BASE + 32'd4, rd, rv);
    check("post_rst_prescale", rd, 32'd0);
    bus_read(BASE + 32'd8, rd, rv);
    check("post_rst_led_duty", rd, 32'd0);
    check("post_rst_led", {31'd0, led}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
